// File: rtl/wb_gw_pkg.sv
// Shared types and constants for the wb_gateway_mux Wishbone gateway.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 5
`endif
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 32
`endif

package wb_gw_pkg;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_OWN,
    GW_DRAIN
  } gw_state_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;
  localparam int unsigned GW_MAX_CH = 8;

endpackage

// File: rtl/wishbone.sv
// Wishbone classic/pipelined bus bundle with master and slave views.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 5
`endif
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 32
`endif

interface wishbone #(
  parameter int unsigned ADDR_W   = `UART_ADDR_WIDTH,
  parameter int unsigned DATA_W   = `UART_DATA_WIDTH,
  parameter int unsigned SELECT_W = 4
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic [SELECT_W-1:0] sel;
  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat_o;
  logic [DATA_W-1:0]   dat_i;
  logic                ack;
  logic                err;

  modport master (output cyc, stb, we, sel, adr, dat_o, input dat_i, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_o, output dat_i, ack, err);
endinterface

// File: rtl/wb_rr_arbiter.sv
// One-hot request arbiter: fixed priority (lowest index) or round-robin from ptr.
// ptr advances to (winner+1) mod NUM_CH whenever en accepts a winner.
module wb_rr_arbiter
  import wb_gw_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] win
);
  localparam int unsigned PTR_W = $clog2(GW_MAX_CH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == ARB_RR) ? (32'(ptr_q) + k) % NUM_CH : k;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!found && (j == idx) && req[j]) begin
          win[j] = 1'b1;
          found  = 1'b1;
          if (en) ptr_d = PTR_W'((j + 1) % NUM_CH);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_gateway_mux.sv
// N-channel Wishbone gateway onto the UART master port: arbitration, cyc-window ownership, response routing.
// Define WB_GW_TIMEOUT_EN to add the stall timeout with err injection and DRAIN recovery.
module wb_gateway_mux
  import wb_gw_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ADDR_W      = `UART_ADDR_WIDTH,
  parameter int unsigned DATA_W      = `UART_DATA_WIDTH,
  parameter int unsigned SELECT_W    = 4,
  parameter int unsigned ARB_MODE    = ARB_FIXED,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_lock,
  wishbone.slave            wb_slave [NUM_CH],
  wishbone.master           wb_master,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              timeout
);
  gw_state_e           state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   cyc_v, stb_v, we_v, req, win, ack_v, err_v;
  logic [SELECT_W-1:0] sel_v [NUM_CH];
  logic [ADDR_W-1:0]   adr_v [NUM_CH];
  logic [DATA_W-1:0]   dat_v [NUM_CH];
  logic                m_cyc, m_stb, m_we;
  logic [SELECT_W-1:0] m_sel;
  logic [ADDR_W-1:0]   m_adr;
  logic [DATA_W-1:0]   m_dat;
  logic                own, owner_cyc, arb_en, abort;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cyc_v[i]          = wb_slave[i].cyc;
    assign stb_v[i]          = wb_slave[i].stb;
    assign we_v[i]           = wb_slave[i].we;
    assign sel_v[i]          = wb_slave[i].sel;
    assign adr_v[i]          = wb_slave[i].adr;
    assign dat_v[i]          = wb_slave[i].dat_o;
    assign wb_slave[i].dat_i = wb_master.dat_i;
    assign wb_slave[i].ack   = ack_v[i];
    assign wb_slave[i].err   = err_v[i];
  end

  assign own       = (state_q == GW_OWN);
  assign owner_cyc = |(cyc_v & grant_q);
  assign req       = cfg_lock ? (cyc_v & NUM_CH'(1)) : cyc_v;
  assign ack_v     = own ? (grant_q & {NUM_CH{wb_master.ack}}) : '0;
  assign err_v     = own ? (grant_q & {NUM_CH{wb_master.err | abort}}) : '0;

  wb_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .en   (arb_en),
    .win  (win)
  );

  // Downstream carries nothing unless an owner is live; DRAIN therefore idles the bus.
  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_sel = '0;
    m_adr = '0;
    m_dat = '0;
    if (own) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (grant_q[i]) begin
          m_cyc = cyc_v[i];
          m_stb = cyc_v[i] & stb_v[i];
          m_we  = we_v[i];
          m_sel = sel_v[i];
          m_adr = adr_v[i];
          m_dat = dat_v[i];
        end
      end
    end
  end

  assign wb_master.cyc   = m_cyc;
  assign wb_master.stb   = m_stb;
  assign wb_master.we    = m_we;
  assign wb_master.sel   = m_sel;
  assign wb_master.adr   = m_adr;
  assign wb_master.dat_o = m_dat;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    arb_en  = 1'b0;
    unique case (state_q)
      GW_IDLE: if (|req) begin
        arb_en  = 1'b1;
        grant_d = win;
        state_d = GW_OWN;
      end
      GW_OWN: if (!owner_cyc) begin
        state_d = GW_IDLE;
        grant_d = '0;
      end else if (abort) begin
        state_d = GW_DRAIN;
      end
      GW_DRAIN: if (!owner_cyc) begin
        state_d = GW_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = GW_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= GW_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef WB_GW_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!own || wb_master.ack || wb_master.err) cnt_d = '0;
    else if (m_stb && (cnt_q != CNT_W'(TIMEOUT_CYC))) cnt_d = cnt_q + CNT_W'(1);
  end

  // An ack arriving in the limit cycle completes the transfer instead of aborting it.
  assign abort = own && owner_cyc && (cnt_q == CNT_W'(TIMEOUT_CYC)) &&
                 !wb_master.ack && !wb_master.err;

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign timeout = abort;

endmodule

// File: tb/tb_wb_gateway_mux.sv
// Directed bench for wb_gateway_mux: a fixed-priority instance (d=0) and a round-robin instance (d=1).
`timescale 1ns/1ps
module tb_wb_gateway_mux;
  import wb_gw_pkg::*;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          c_lock [2];
  logic          c_cyc  [2][NCH];
  logic          c_stb  [2][NCH];
  logic          c_we   [2][NCH];
  logic [SW-1:0] c_sel  [2][NCH];
  logic [AW-1:0] c_adr  [2][NCH];
  logic [DW-1:0] c_dat  [2][NCH];
  logic          m_ack  [2];
  logic          m_err  [2];
  logic [DW-1:0] m_dati [2];

  wire           o_ack  [2][NCH];
  wire           o_err  [2][NCH];
  wire [DW-1:0]  o_dat  [2][NCH];
  wire           m_cyc  [2];
  wire           m_stb  [2];
  wire           m_we   [2];
  wire [SW-1:0]  m_sel  [2];
  wire [AW-1:0]  m_adr  [2];
  wire [DW-1:0]  m_dato [2];
  wire [NCH-1:0] gnt    [2];
  wire           bsy    [2];
  wire           tmo    [2];

  wishbone #(.ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW)) up0 [NCH] ();
  wishbone #(.ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW)) up1 [NCH] ();
  wishbone #(.ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW)) dn0 ();
  wishbone #(.ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW)) dn1 ();

  for (genvar i = 0; i < NCH; i++) begin : g_up
    assign up0[i].cyc   = c_cyc[0][i];
    assign up0[i].stb   = c_stb[0][i];
    assign up0[i].we    = c_we[0][i];
    assign up0[i].sel   = c_sel[0][i];
    assign up0[i].adr   = c_adr[0][i];
    assign up0[i].dat_o = c_dat[0][i];
    assign o_ack[0][i]  = up0[i].ack;
    assign o_err[0][i]  = up0[i].err;
    assign o_dat[0][i]  = up0[i].dat_i;
    assign up1[i].cyc   = c_cyc[1][i];
    assign up1[i].stb   = c_stb[1][i];
    assign up1[i].we    = c_we[1][i];
    assign up1[i].sel   = c_sel[1][i];
    assign up1[i].adr   = c_adr[1][i];
    assign up1[i].dat_o = c_dat[1][i];
    assign o_ack[1][i]  = up1[i].ack;
    assign o_err[1][i]  = up1[i].err;
    assign o_dat[1][i]  = up1[i].dat_i;
  end

  assign dn0.ack   = m_ack[0];
  assign dn0.err   = m_err[0];
  assign dn0.dat_i = m_dati[0];
  assign m_cyc[0]  = dn0.cyc;
  assign m_stb[0]  = dn0.stb;
  assign m_we[0]   = dn0.we;
  assign m_sel[0]  = dn0.sel;
  assign m_adr[0]  = dn0.adr;
  assign m_dato[0] = dn0.dat_o;
  assign dn1.ack   = m_ack[1];
  assign dn1.err   = m_err[1];
  assign dn1.dat_i = m_dati[1];
  assign m_cyc[1]  = dn1.cyc;
  assign m_stb[1]  = dn1.stb;
  assign m_we[1]   = dn1.we;
  assign m_sel[1]  = dn1.sel;
  assign m_adr[1]  = dn1.adr;
  assign m_dato[1] = dn1.dat_o;

  wb_gateway_mux #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYC(4)
  ) u_fix (
    .clk(clk), .rstn(rstn), .cfg_lock(c_lock[0]), .wb_slave(up0), .wb_master(dn0),
    .grant(gnt[0]), .busy(bsy[0]), .timeout(tmo[0])
  );

  wb_gateway_mux #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW), .ARB_MODE(ARB_RR), .TIMEOUT_CYC(4)
  ) u_rr (
    .clk(clk), .rstn(rstn), .cfg_lock(c_lock[1]), .wb_slave(up1), .wb_master(dn1),
    .grant(gnt[1]), .busy(bsy[1]), .timeout(tmo[1])
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle_all(input int unsigned d);
    for (int unsigned i = 0; i < NCH; i++) begin
      c_cyc[d][i] = 1'b0;
      c_stb[d][i] = 1'b0;
      c_we[d][i]  = 1'b0;
    end
  endtask

  task automatic req_on(input int unsigned d, input int unsigned ch);
    c_cyc[d][ch] = 1'b1;
    c_stb[d][ch] = 1'b1;
  endtask

  // Every channel keeps requesting; each owner takes one ack, drops cyc for one cycle, re-raises.
  task automatic owner_seq(input int unsigned d, input int unsigned e0, input int unsigned e1,
                           input int unsigned e2, input int unsigned e3);
    int unsigned exp_o [4];
    exp_o = '{e0, e1, e2, e3};
    idle_all(d);
    step(2);
    for (int unsigned i = 0; i < NCH; i++) req_on(d, i);
    step();
    for (int unsigned n = 0; n < 4; n++) begin
      chk($sformatf("seq%0d_grant%0d", d, n), 32'(gnt[d]), 32'(1 << exp_o[n]));
      m_ack[d] = 1'b1;
      #1;
      for (int unsigned i = 0; i < NCH; i++)
        chk($sformatf("seq%0d_ack%0d_ch%0d", d, n, i), 32'(o_ack[d][i]), 32'(i == exp_o[n]));
      step();
      m_ack[d] = 1'b0;
      c_cyc[d][exp_o[n]] = 1'b0;
      c_stb[d][exp_o[n]] = 1'b0;
      chk($sformatf("seq%0d_hold%0d", d, n), 32'(gnt[d]), 32'(1 << exp_o[n]));
      step();
      chk($sformatf("seq%0d_dead%0d", d, n), 32'(gnt[d]), 32'h0);
      chk($sformatf("seq%0d_deadbusy%0d", d, n), 32'(bsy[d]), 32'h0);
      req_on(d, exp_o[n]);
      step();
    end
    idle_all(d);
    step(2);
  endtask

  initial begin
    rstn = 1'b0;
    for (int unsigned d = 0; d < 2; d++) begin
      c_lock[d] = 1'b0;
      m_ack[d]  = 1'b1;
      m_err[d]  = 1'b1;
      m_dati[d] = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        c_cyc[d][i] = 1'b1;
        c_stb[d][i] = 1'b1;
        c_we[d][i]  = 1'b0;
        c_sel[d][i] = SW'(1 << i);
        c_adr[d][i] = AW'(i + 1);
        c_dat[d][i] = 32'hA000_0000 + i;
      end
    end

    // Reset with every channel requesting and the slave asserting ack/err.
    step(3);
    for (int unsigned d = 0; d < 2; d++) begin
      chk($sformatf("rst_grant%0d", d), 32'(gnt[d]), 32'h0);
      chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'h0);
      chk($sformatf("rst_tmo%0d", d), 32'(tmo[d]), 32'h0);
      chk($sformatf("rst_mcyc%0d", d), 32'(m_cyc[d]), 32'h0);
      chk($sformatf("rst_mstb%0d", d), 32'(m_stb[d]), 32'h0);
      chk($sformatf("rst_mwe%0d", d), 32'(m_we[d]), 32'h0);
      chk($sformatf("rst_madr%0d", d), 32'(m_adr[d]), 32'h0);
      chk($sformatf("rst_msel%0d", d), 32'(m_sel[d]), 32'h0);
      chk($sformatf("rst_mdat%0d", d), m_dato[d], 32'h0);
      for (int unsigned i = 0; i < NCH; i++) begin
        chk($sformatf("rst_ack%0d_ch%0d", d, i), 32'(o_ack[d][i]), 32'h0);
        chk($sformatf("rst_err%0d_ch%0d", d, i), 32'(o_err[d][i]), 32'h0);
      end
    end
    m_ack[0] = 1'b0; m_err[0] = 1'b0;
    m_ack[1] = 1'b0; m_err[1] = 1'b0;
    idle_all(1);
    rstn = 1'b1;
    step();
    chk("first_grant", 32'(gnt[0]), 32'h1);
    chk("first_busy", 32'(bsy[0]), 32'h1);
    chk("first_mcyc", 32'(m_cyc[0]), 32'h1);
    chk("first_madr", 32'(m_adr[0]), 32'h1);
    chk("rr_untouched", 32'(gnt[1]), 32'h0);
    idle_all(0);
    step(2);
    chk("release_grant", 32'(gnt[0]), 32'h0);

    // Round-robin rotates 0,1,2,0; fixed priority keeps returning to channel 0.
    owner_seq(1, 0, 1, 2, 0);
    owner_seq(0, 0, 0, 0, 0);

    // stb without cyc is not a request.
    c_stb[0][2] = 1'b1;
    step(2);
    chk("stb_only_grant", 32'(gnt[0]), 32'h0);
    chk("stb_only_mstb", 32'(m_stb[0]), 32'h0);
    idle_all(0);

    // cfg_lock reserves the bus for channel 0.
    c_lock[0] = 1'b1;
    req_on(0, 1);
    req_on(0, 2);
    step(2);
    chk("lock_nogrant", 32'(gnt[0]), 32'h0);
    chk("lock_mcyc", 32'(m_cyc[0]), 32'h0);
    req_on(0, 0);
    step();
    chk("lock_ch0", 32'(gnt[0]), 32'h1);
    idle_all(0);
    c_lock[0] = 1'b0;
    step(2);

    // No preemption: channel 1 owns while channel 0 requests and lock rises.
    req_on(0, 1);
    step();
    chk("own1_grant", 32'(gnt[0]), 32'h2);
    req_on(0, 0);
    c_lock[0]  = 1'b1;
    m_ack[0]   = 1'b1;
    m_err[0]   = 1'b1;
    m_dati[0]  = 32'h5A5A_1234;
    #1;
    chk("own1_ack1", 32'(o_ack[0][1]), 32'h1);
    chk("own1_err1", 32'(o_err[0][1]), 32'h1);
    chk("own1_madr", 32'(m_adr[0]), 32'h2);
    chk("fanout_dat0", o_dat[0][0], 32'h5A5A_1234);
    for (int unsigned n = 0; n < 3; n++) begin
      chk($sformatf("nopre_grant%0d", n), 32'(gnt[0]), 32'h2);
      chk($sformatf("nopre_ack0_%0d", n), 32'(o_ack[0][0]), 32'h0);
      chk($sformatf("nopre_err0_%0d", n), 32'(o_err[0][0]), 32'h0);
      step();
    end
    m_ack[0] = 1'b0;
    m_err[0] = 1'b0;
    c_cyc[0][1] = 1'b0;
    c_stb[0][1] = 1'b0;
    step();
    chk("handover_idle", 32'(gnt[0]), 32'h0);
    step();
    chk("handover_ch0", 32'(gnt[0]), 32'h1);
    idle_all(0);
    c_lock[0] = 1'b0;
    step(2);

`ifdef WB_GW_TIMEOUT_EN
    // Stalled slave: err after four stalled cycles, then DRAIN until the owner lets go.
    req_on(0, 0);
    req_on(0, 1);
    for (int unsigned n = 0; n < 4; n++) begin
      step();
      chk($sformatf("stall_err%0d", n), 32'(o_err[0][0]), 32'h0);
      chk($sformatf("stall_tmo%0d", n), 32'(tmo[0]), 32'h0);
    end
    step();
    chk("abort_err", 32'(o_err[0][0]), 32'h1);
    chk("abort_tmo", 32'(tmo[0]), 32'h1);
    chk("abort_err_other", 32'(o_err[0][1]), 32'h0);
    step();
    chk("drain_mcyc", 32'(m_cyc[0]), 32'h0);
    chk("drain_mstb", 32'(m_stb[0]), 32'h0);
    chk("drain_tmo", 32'(tmo[0]), 32'h0);
    chk("drain_err", 32'(o_err[0][0]), 32'h0);
    chk("drain_grant", 32'(gnt[0]), 32'h1);
    step();
    chk("drain_hold", 32'(m_cyc[0]), 32'h0);
    c_cyc[0][0] = 1'b0;
    c_stb[0][0] = 1'b0;
    step();
    chk("drain_idle", 32'(gnt[0]), 32'h0);
    step();
    chk("drain_next", 32'(gnt[0]), 32'h2);
    chk("drain_next_mcyc", 32'(m_cyc[0]), 32'h1);
    // Ack landing in the limit cycle wins over the abort.
    step(4);
    m_ack[0] = 1'b1;
    #1;
    chk("limit_ack", 32'(o_ack[0][1]), 32'h1);
    chk("limit_noerr", 32'(o_err[0][1]), 32'h0);
    chk("limit_notmo", 32'(tmo[0]), 32'h0);
    step();
    m_ack[0] = 1'b0;
    chk("limit_owner", 32'(gnt[0]), 32'h2);
    chk("limit_mcyc", 32'(m_cyc[0]), 32'h1);
    idle_all(0);
    step(2);
`else
    // Without the timeout a stalled slave keeps the bus.
    req_on(0, 0);
    step(9);
    chk("stall_grant", 32'(gnt[0]), 32'h1);
    chk("stall_mcyc", 32'(m_cyc[0]), 32'h1);
    chk("stall_err", 32'(o_err[0][0]), 32'h0);
    chk("stall_tmo", 32'(tmo[0]), 32'h0);
    idle_all(0);
    step(2);
`endif

    // Reset in the middle of a write.
    req_on(0, 0);
    c_we[0][0] = 1'b1;
    step();
    chk("wr_grant", 32'(gnt[0]), 32'h1);
    chk("wr_mwe", 32'(m_we[0]), 32'h1);
    chk("wr_mstb", 32'(m_stb[0]), 32'h1);
    chk("wr_msel", 32'(m_sel[0]), 32'h1);
    chk("wr_mdat", m_dato[0], 32'hA000_0000);
    rstn = 1'b0;
    step();
    chk("mid_rst_grant", 32'(gnt[0]), 32'h0);
    chk("mid_rst_mcyc", 32'(m_cyc[0]), 32'h0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'h0);
    m_ack[0] = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(o_ack[0][0]), 32'h0);
    step();
    chk("mid_rst_ack2", 32'(o_ack[0][0]), 32'h0);
    m_ack[0] = 1'b0;
    idle_all(0);
    rstn = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_gateway_mux.md
# wb_gateway_mux

Parametrised N-channel Wishbone master gateway for the UART IO path: arbitrates NUM_CH upstream Wishbone masters onto a single downstream Wishbone master port toward the UART IP. It supersedes the fixed 3-to-1 select-driven mux with the following behaviour:

- internal arbitration, fixed-priority or round-robin;
- bus ownership locked for the whole `cyc` window;
- a configuration lock that reserves the bus for channel 0;
- optional transaction timeout.

## Interface
Parameters:
- `NUM_CH`, 3, number of upstream channels (1..8).
- `ADDR_W`, `` `UART_ADDR_WIDTH ``, Wishbone address width.
- `DATA_W`, `` `UART_DATA_WIDTH ``, Wishbone data width.
- `SELECT_W`, 4, byte-select width.
- `ARB_MODE`, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `TIMEOUT_CYC`, 255, stall limit in cycles; used only with `WB_GW_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: clock, all state on rising edge.
- `rstn` input 1: synchronous active-low reset.
- `cfg_lock` input 1: while high, only channel 0 may win arbitration.
- `wb_slave[NUM_CH]` wishbone.slave, interface array: upstream channels. Fields used: `cyc`, `stb`, `we`, `sel`, `adr`, `dat_o`, `dat_i`, `ack`, `err`.
- `wb_master` wishbone.master, interface: downstream port to the UART.
- `grant` output NUM_CH: one-hot current owner; all-zero when idle.
- `busy` output 1: high while any channel owns the bus.
- `timeout` output 1: one-cycle pulse on abort; tied 0 without `WB_GW_TIMEOUT_EN`.

## Operation
FSM states:
- **IDLE**: no owner.
  - Requesters are channels with `cyc` high, masked to channel 0 only when `cfg_lock` is high.
  - If any requester exists, the winner is registered into `grant` and the FSM goes to OWN.
- **OWN**: the owner's `cyc`, `stb`, `we`, `sel`, `adr` and `dat_o` drive `wb_master` combinationally.
  - `wb_master.ack` and `wb_master.err` route to the owner only; non-owners see `ack` = `err` = 0.
  - `wb_master.dat_i` fans out to all channels.
  - When the owner's `cyc` goes low, the FSM goes to IDLE and `grant` clears.
- **DRAIN** (timeout build only): `wb_master.cyc` and `wb_master.stb` are forced 0.
  - The FSM waits for the owner's `cyc` to go low, then goes to IDLE.

Arbitration:
- Fixed priority: lowest requesting index wins.
- Round-robin: the search starts at `ptr`.
  - `ptr` loads (winner+1) mod NUM_CH on each grant.
  - `ptr` resets to 0.

Rules:
- No preemption. A `cfg_lock` change or a higher-priority request never affects the current owner; it applies at the next IDLE arbitration.
- Owner `stb` without `cyc` is ignored. `wb_master` carries `cyc` = `stb` = 0 when there is no owner.
- NUM_CH = 1 is legal: `grant` is 1 whenever that channel owns the bus.

## Timing
- Reset: FSM = IDLE, `grant` = 0, `busy` = 0, `timeout` = 0, `ptr` = 0.
  - `wb_master.cyc`, `wb_master.stb`, `wb_master.we` = 0; `adr`, `dat_o`, `sel` = 0.
  - All upstream `ack` and `err` = 0.
- Reset asserted mid-transfer: ownership is dropped at that edge and `wb_master.cyc` is 0 in the following cycle.
- Grant latency: `cyc` rises at edge n, so `grant` and `wb_master.cyc` are high from cycle n+1.
- Handover: owner `cyc` falls during cycle m, so IDLE is cycle m+1 and the next owner is granted at m+2. There is exactly one dead cycle between owners.
- `ack` and `err` pass through combinationally with zero added latency. Pipelined/back-to-back strobes within one `cyc` window are passed unchanged.
- Timeout counter:
  - width is `$clog2(TIMEOUT_CYC+1)`;
  - clears on ack, on err, and whenever the FSM is not in OWN;
  - increments each OWN cycle with owner `stb` high and no ack.
- Timeout abort: when the counter reaches TIMEOUT_CYC, the owner gets a one-cycle `err`, `timeout` pulses, and the FSM goes to DRAIN.
- Ack on the same cycle the limit is reached: the ack wins and no abort occurs.

## Configuration
- Macro: `WB_GW_TIMEOUT_EN`.
- Defined: the timeout counter, DRAIN state, `err` injection and `timeout` pulse are present.
- Undefined: none of that logic exists, `timeout` is tied 0, and a stalled slave holds the bus indefinitely.

## Structure
- Package `wb_gw_pkg` holds:
  - the FSM state enum (`GW_IDLE`, `GW_OWN`, `GW_DRAIN`);
  - `ARB_FIXED` = 0 and `ARB_RR` = 1;
  - the maximum channel constant `GW_MAX_CH` = 8.
- Sub-module `wb_rr_arbiter` (parameters NUM_CH, ARB_MODE):
  - inputs: `req` and `en`;
  - output: one-hot `win`;
  - owns `ptr` and updates it when `en` is high.
- Top level holds the FSM, muxing, response routing and timeout logic.

## Test plan
- Reset with all channels requesting → all outputs 0 during reset. First edge after reset release: fixed mode grants channel 0, `grant` = 3'b001.
- `cfg_lock` = 1, channels 1 and 2 request → no grant. Channel 0 requests → `grant` = 3'b001 one cycle later.
- ARB_MODE = 1, all three channels hold `cyc` and drop it after one ack each → grant order 0, 1, 2, 0, with exactly one idle cycle between owners.
- Channel 1 owns the bus and channel 0 raises `cyc` → channel 1 keeps the bus until its `cyc` falls. No ack or err ever reaches channel 0 meanwhile.
- Timeout build, TIMEOUT_CYC = 4, slave never acks → owner sees `err` after 4 stalled cycles and `timeout` pulses once. `wb_master.cyc` = 0 until the owner drops `cyc`, then the next requester is granted.
- `rstn` asserted during a write with `stb` high → `wb_master.cyc` = 0 and `grant` = 0 the next cycle. No stray ack reaches the former owner.
